// File: rtl/string_art_pkg.sv
// Shared types and default geometry for the string-art line-selection datapath.
package string_art_pkg;

  localparam int unsigned PIN_W    = 8;
  localparam int unsigned NUM_PINS = 200;

  typedef logic [PIN_W-1:0] pin_t;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SEARCH,
    RESP
  } state_t;

endpackage

// File: rtl/line_bitmap.sv
// NUM_PINS x NUM_PINS drawn-line store: row = lower pin, bit = higher pin.
// One-row clear, single-bit toggle, combinational read.
module line_bitmap #(
  parameter int unsigned NUM_PINS = string_art_pkg::NUM_PINS,
  parameter int unsigned PIN_W    = string_art_pkg::PIN_W
) (
  input  logic             clk,
  input  logic             i_clr_en,
  input  logic [PIN_W-1:0] i_clr_row,
  input  logic             i_tgl_en,
  input  logic [PIN_W-1:0] i_tgl_row,
  input  logic [PIN_W-1:0] i_tgl_col,
  input  logic [PIN_W-1:0] i_rd_row,
  input  logic [PIN_W-1:0] i_rd_col,
  output logic             o_rd_bit
);

  // Index only with the bits needed to address NUM_PINS entries.
  localparam int unsigned IDX_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;

  logic [NUM_PINS-1:0] r_rows [NUM_PINS];

  // Row clear takes priority; the engine never clears and toggles together.
  always_ff @(posedge clk) begin
    if (i_clr_en) begin
      r_rows[i_clr_row[IDX_W-1:0]] <= '0;
    end else if (i_tgl_en) begin
      r_rows[i_tgl_row[IDX_W-1:0]][i_tgl_col[IDX_W-1:0]] <=
        ~r_rows[i_tgl_row[IDX_W-1:0]][i_tgl_col[IDX_W-1:0]];
    end
  end

  assign o_rd_bit = r_rows[i_rd_row[IDX_W-1:0]][i_rd_col[IDX_W-1:0]];

endmodule

// File: rtl/add_remove_search.sv
// Line-selection engine: scans chords from a persistent cursor, returns the next
// admissible chord with add/remove, tracks drawn lines and the operation budget.
module add_remove_search #(
  parameter int unsigned NUM_PINS = string_art_pkg::NUM_PINS,
  parameter int unsigned PIN_W    = string_art_pkg::PIN_W,
  parameter int unsigned MIN_GAP  = 10,
  parameter int unsigned MAX_OPS  = 2000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  input  logic             resp_rdy,
  output logic             resp_val,
  output logic [PIN_W-1:0] pin_1_index,
  output logic [PIN_W-1:0] pin_2_index,
  output logic             add_or_remove,
  output logic             done
);

  import string_art_pkg::*;

  // One extra bit so cursor increments past NUM_PINS-1 cannot overflow.
  localparam int unsigned CW    = PIN_W + 1;
  localparam int unsigned OPS_W = $clog2(MAX_OPS + 1);

  localparam logic [CW-1:0]    C_NPINS    = CW'(NUM_PINS);
  localparam logic [CW-1:0]    C_GAP      = CW'(MIN_GAP);
  localparam logic [CW-1:0]    C_LAST1    = CW'(NUM_PINS - 1);
  localparam logic [CW-1:0]    C_LAST2    = CW'(NUM_PINS - 2);
  localparam logic [PIN_W-1:0] C_ROW_LAST = PIN_W'(NUM_PINS - 1);
  localparam logic [OPS_W-1:0] C_MAX      = OPS_W'(MAX_OPS);

  state_t           r_state;
  state_t           w_next_state;
  logic [PIN_W-1:0] r_clear_row;
  logic [PIN_W-1:0] r_cur_p1;
  logic [PIN_W-1:0] r_cur_p2;
  logic [PIN_W-1:0] r_pin1;
  logic [PIN_W-1:0] r_pin2;
  logic             r_add;
  logic             r_done;
  logic [OPS_W-1:0] r_op_cnt;

  logic             w_bit;
  logic             w_adm;
  logic             w_hs;
  logic             w_clr_en;
  logic             w_adv;
  logic             w_latch;
  logic             w_resp_val;
  logic             w_clear_last;
  logic [CW-1:0]    w_dist;
  logic [CW-1:0]    w_p1_inc;
  logic [CW-1:0]    w_p2_inc;
  logic [PIN_W-1:0] w_nxt_p1;
  logic [PIN_W-1:0] w_nxt_p2;

  line_bitmap #(
    .NUM_PINS(NUM_PINS),
    .PIN_W   (PIN_W)
  ) u_bitmap (
    .clk      (clk),
    .i_clr_en (w_clr_en),
    .i_clr_row(r_clear_row),
    .i_tgl_en (w_hs),
    .i_tgl_row(r_pin1),
    .i_tgl_col(r_pin2),
    .i_rd_row (r_cur_p1),
    .i_rd_col (r_cur_p2),
    .o_rd_bit (w_bit)
  );

  // Admissible when the chord spans at least MIN_GAP pins both ways round the hoop.
  always_comb begin
    w_dist = {1'b0, r_cur_p2} - {1'b0, r_cur_p1};
    w_adm  = (w_dist >= C_GAP) && ((C_NPINS - w_dist) >= C_GAP);
  end

  // Next cursor position: step pin_2, roll to the next row, wrap to (0,1) after the last row.
  always_comb begin
    w_p1_inc = {1'b0, r_cur_p1} + CW'(1);
    w_p2_inc = {1'b0, r_cur_p2} + CW'(1);
    w_nxt_p1 = r_cur_p1;
    w_nxt_p2 = w_p2_inc[PIN_W-1:0];
    if (w_p2_inc > C_LAST1) begin
      if (w_p1_inc > C_LAST2) begin
        w_nxt_p1 = '0;
        w_nxt_p2 = PIN_W'(1);
      end else begin
        w_nxt_p1 = w_p1_inc[PIN_W-1:0];
        w_nxt_p2 = w_p1_inc[PIN_W-1:0] + PIN_W'(1);
      end
    end
  end

  assign w_clear_last = (r_clear_row == C_ROW_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= CLEAR;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      CLEAR:  if (w_clear_last)         w_next_state = IDLE;
      IDLE:   if (!r_done && req_val)   w_next_state = SEARCH;
      SEARCH: if (w_adm)                w_next_state = RESP;
      RESP:   if (resp_rdy)             w_next_state = IDLE;
      default:                          w_next_state = CLEAR;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    w_clr_en   = (r_state == CLEAR);
    w_resp_val = (r_state == RESP);
    w_hs       = (r_state == RESP) && resp_rdy;
    w_latch    = (r_state == SEARCH) && w_adm;
    w_adv      = ((r_state == SEARCH) && !w_adm) || w_hs;
  end

  // Clear-row pointer walks rows 0..NUM_PINS-1 once per reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_clear_row <= '0;
    else if (w_clr_en) r_clear_row <= w_clear_last ? '0 : r_clear_row + PIN_W'(1);
  end

  // Cursor persists across requests; it moves on a rejected pair or past an accepted one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_p1 <= '0;
      r_cur_p2 <= PIN_W'(1);
    end else if (w_adv) begin
      r_cur_p1 <= w_nxt_p1;
      r_cur_p2 <= w_nxt_p2;
    end
  end

  // Latch the admissible chord; add when the line is not yet drawn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pin1 <= '0;
      r_pin2 <= '0;
      r_add  <= 1'b0;
    end else if (w_latch) begin
      r_pin1 <= r_cur_p1;
      r_pin2 <= r_cur_p2;
      r_add  <= ~w_bit;
    end
  end

  // Operation budget: count handshakes, freeze at MAX_OPS and raise a sticky done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_cnt <= '0;
      r_done   <= 1'b0;
    end else if (w_hs && (r_op_cnt != C_MAX)) begin
      r_op_cnt <= r_op_cnt + OPS_W'(1);
      if ((r_op_cnt + OPS_W'(1)) == C_MAX) r_done <= 1'b1;
    end
  end

  assign resp_val      = w_resp_val;
  assign pin_1_index   = r_pin1;
  assign pin_2_index   = r_pin2;
  assign add_or_remove = r_add;
  assign done          = r_done;

endmodule

// File: tb/tb_add_remove_search.sv
// Scoreboard bench for add_remove_search: a default-geometry instance and a small
// 20-pin instance run side by side against an ordered-chord reference model.
`timescale 1ns/1ps
module tb_add_remove_search;

  localparam int NP_B  = 200;
  localparam int GAP_B = 10;
  localparam int MAX_B = 40000;
  localparam int NP_S  = 20;
  localparam int GAP_S = 5;
  localparam int MAX_S = 250;
  localparam int GUARD = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic       req  [2];
  logic       rdy  [2];
  logic       val  [2];
  logic [7:0] p1o  [2];
  logic [7:0] p2o  [2];
  logic       addo [2];
  logic       doneo[2];

  add_remove_search #(
    .NUM_PINS(NP_B), .PIN_W(8), .MIN_GAP(GAP_B), .MAX_OPS(MAX_B)
  ) u_big (
    .clk(clk), .reset(rst[0]), .req_val(req[0]), .resp_rdy(rdy[0]),
    .resp_val(val[0]), .pin_1_index(p1o[0]), .pin_2_index(p2o[0]),
    .add_or_remove(addo[0]), .done(doneo[0])
  );

  add_remove_search #(
    .NUM_PINS(NP_S), .PIN_W(8), .MIN_GAP(GAP_S), .MAX_OPS(MAX_S)
  ) u_small (
    .clk(clk), .reset(rst[1]), .req_val(req[1]), .resp_rdy(rdy[1]),
    .resp_val(val[1]), .pin_1_index(p1o[1]), .pin_2_index(p2o[1]),
    .add_or_remove(addo[1]), .done(doneo[1])
  );

  // Reference: every admissible chord of a pass in scan order, tagged with its
  // position among all pairs so the scan latency between responses is known.
  typedef struct { int p1; int p2; int sidx; } chord_t;
  typedef struct { int p1; int p2; int add; int lat; } exp_t;

  chord_t ord[$];
  int base[2], plen[2], npairs[2], npin[2], maxops[2];
  int issued[2], ops_seen[2], mark[2];
  exp_t q0[$], q1[$];
  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit prev_val[2], prev_rdy[2], prev_rst[2];
  int prev_p1[2], prev_p2[2], prev_add[2];

  function automatic void check(int id, string nm, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %0d, expected %0d (t=%0t)", id, nm, act, want, $time);
    end
  endfunction

  function automatic void timeout(int id, string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL dut%0d timeout in %s: got no progress, expected handshake (t=%0t)", id, nm, $time);
  endfunction

  function automatic void build(int id, int np, int gap, int mx);
    int s = 0;
    base[id] = ord.size();
    for (int a = 0; a < np - 1; a++)
      for (int b = a + 1; b < np; b++) begin
        if ((b - a) >= gap && (np - (b - a)) >= gap) ord.push_back('{a, b, s});
        s++;
      end
    plen[id]   = ord.size() - base[id];
    npairs[id] = s;
    npin[id]   = np;
    maxops[id] = mx;
  endfunction

  // Response n: chord n mod pass-length; every pass flips every chord, so even
  // passes add and odd passes remove. Latency counts cursor positions tested.
  function automatic exp_t model_next(int id);
    exp_t   e;
    chord_t c;
    chord_t pv;
    int     n = issued[id];
    c     = ord[base[id] + n % plen[id]];
    e.p1  = c.p1;
    e.p2  = c.p2;
    e.add = ((n / plen[id]) % 2 == 0) ? 1 : 0;
    if (n == 0) begin
      e.lat = npin[id] + 1 + c.sidx + 1;
    end else begin
      pv    = ord[base[id] + (n - 1) % plen[id]];
      e.lat = (c.sidx - pv.sidx - 1 + npairs[id]) % npairs[id] + 1 + 2;
    end
    issued[id] = n + 1;
    return e;
  endfunction

  function automatic int qsize(int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(int id, exp_t e);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endfunction

  function automatic exp_t qpop(int id);
    if (id == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void qclear(int id);
    if (id == 0) q0.delete();
    else         q1.delete();
  endfunction

  // Monitor: pops on each new response, checks stability under backpressure,
  // done against handshakes seen, and latency from the previous handshake.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    for (int id = 0; id < 2; id++) begin
      if (!rst[id]) begin
        prev_rst[id] = 1'b0;
        prev_val[id] = 1'b0;
      end else begin
        if (!prev_rst[id]) begin
          mark[id]     = cyc;
          prev_rst[id] = 1'b1;
        end
        check(id, "done", int'(doneo[id]), (ops_seen[id] >= maxops[id]) ? 1 : 0);
        if (val[id] && !prev_val[id]) begin
          if (qsize(id) == 0) begin
            check(id, "resp_val_unexpected", int'(val[id]), 0);
          end else begin
            e = qpop(id);
            check(id, "pin_1", int'(p1o[id]), e.p1);
            check(id, "pin_2", int'(p2o[id]), e.p2);
            check(id, "add_or_remove", int'(addo[id]), e.add);
            check(id, "latency", cyc - mark[id], e.lat);
          end
        end else if (val[id] && prev_val[id]) begin
          if (prev_rdy[id]) begin
            check(id, "resp_val_after_handshake", int'(val[id]), 0);
          end else begin
            check(id, "hold_pin_1", int'(p1o[id]), prev_p1[id]);
            check(id, "hold_pin_2", int'(p2o[id]), prev_p2[id]);
            check(id, "hold_add", int'(addo[id]), prev_add[id]);
          end
        end
        if (val[id] && rdy[id]) begin
          ops_seen[id]++;
          mark[id] = cyc;
        end
        prev_val[id] = val[id];
        prev_rdy[id] = rdy[id];
        prev_p1[id]  = int'(p1o[id]);
        prev_p2[id]  = int'(p2o[id]);
        prev_add[id] = int'(addo[id]);
      end
    end
  end

  task automatic step(input int id);
    @(posedge clk);
    #1;
    if (qsize(id) == 0 && issued[id] < maxops[id]) qpush(id, model_next(id));
  endtask

  task automatic drive(input int id, input int target);
    int g = 0;
    req[id] = 1'b1;
    while (ops_seen[id] < target && g < GUARD) begin
      step(id);
      rdy[id] = ($urandom_range(0, 3) != 0);
      g++;
    end
    if (g >= GUARD) timeout(id, "drive");
  endtask

  task automatic wait_val(input int id);
    int g = 0;
    rdy[id] = 1'b0;
    while (!val[id] && g < GUARD) begin
      step(id);
      g++;
    end
    if (g >= GUARD) timeout(id, "wait_val");
  endtask

  task automatic check_zero(input int id, input string tag);
    check(id, {tag, "_resp_val"}, int'(val[id]), 0);
    check(id, {tag, "_pin_1"}, int'(p1o[id]), 0);
    check(id, {tag, "_pin_2"}, int'(p2o[id]), 0);
    check(id, {tag, "_add"}, int'(addo[id]), 0);
    check(id, {tag, "_done"}, int'(doneo[id]), 0);
  endtask

  initial begin
    build(0, NP_B, GAP_B, MAX_B);
    build(1, NP_S, GAP_S, MAX_S);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; req[i] = 1'b0; rdy[i] = 1'b0;
      issued[i] = 0; ops_seen[i] = 0; mark[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    fork
      begin
        drive(0, 150);
        wait_val(0);
        repeat (5) step(0);
        check(0, "backpressure_resp_val", int'(val[0]), 1);
        drive(0, 200);
        wait_val(0);
        rst[0] = 1'b0;
        #1;
        check_zero(0, "midresp_reset");
        qclear(0);
        issued[0]   = 0;
        ops_seen[0] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        drive(0, 40);
      end
      begin
        drive(1, MAX_S);
        rdy[1] = 1'b1;
        repeat (60) step(1);
        check(1, "after_done_resp_val", int'(val[1]), 0);
        check(1, "after_done_done", int'(doneo[1]), 1);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
